// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the RV32I pipeline.
// Shadows in-flight writes EX..WB; drives stall, flush, bubble, operands.
module hazard_fwd_unit #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 1,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [RA_W-1:0]         id_rs1_addr,
  input  logic [RA_W-1:0]         id_rs2_addr,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [RA_W-1:0]         id_rd_addr,
  input  logic                    id_rf_wen,
  input  logic                    id_is_load,
  input  logic [XLEN-1:0]         rf_rs1_data,
  input  logic [XLEN-1:0]         rf_rs2_data,
  input  logic [DEPTH*XLEN-1:0]   stage_data,
  input  logic                    ex_redirect,
  output logic                    stall,
  output logic                    flush,
  output logic                    bubble,
  output logic [XLEN-1:0]         rs1_value,
  output logic [XLEN-1:0]         rs2_value,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic            wen;
    logic [RA_W-1:0] rd;
    logic            is_load;
  } shadow_t;

  shadow_t         ent_q [DEPTH];
  logic [XLEN-1:0] sd    [DEPTH];

  logic            hit1;
  logic            hit2;
  logic            ld1;
  logic            ld2;
  logic            early1;
  logic            early2;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic            haz1;
  logic            haz2;
  logic            issue;
  shadow_t         id_ent;

  for (genvar g = 0; g < DEPTH; g++) begin : g_sd
    assign sd[g] = stage_data[g*XLEN +: XLEN];
  end

  function automatic logic src_match(
    input shadow_t         e,
    input logic [RA_W-1:0] rs,
    input logic            used
  );
    return e.valid & e.wen & used &
           (rs != '0) & (e.rd == rs);
  endfunction

  // Scan oldest to youngest so the lowest-index match wins.
  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    ld1    = 1'b0;
    ld2    = 1'b0;
    early1 = 1'b0;
    early2 = 1'b0;
    fwd1   = '0;
    fwd2   = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (src_match(ent_q[k], id_rs1_addr, id_rs1_used)) begin
        hit1   = 1'b1;
        ld1    = ent_q[k].is_load;
        early1 = (k < LOAD_RDY);
        fwd1   = sd[k];
      end
      if (src_match(ent_q[k], id_rs2_addr, id_rs2_used)) begin
        hit2   = 1'b1;
        ld2    = ent_q[k].is_load;
        early2 = (k < LOAD_RDY);
        fwd2   = sd[k];
      end
    end
  end

  // A match is a hazard only if its value cannot be forwarded yet.
  always_comb begin
    haz1 = hit1;
    haz2 = hit2;
    if (FWD_EN != 0) begin
      haz1 = hit1 & ld1 & early1;
      haz2 = hit2 & ld2 & early2;
    end
  end

  // Control outputs and operand mux; redirect overrides any stall.
  always_comb begin
    stall     = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b1;
    rs1_value = rf_rs1_data;
    rs2_value = rf_rs2_data;
    if (!reset) begin
      flush  = ex_redirect;
      stall  = id_valid & ~ex_redirect & (haz1 | haz2);
      bubble = stall | flush | ~id_valid;
      if (FWD_EN != 0) begin
        if (hit1) rs1_value = fwd1;
        if (hit2) rs2_value = fwd2;
      end
    end
  end

  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    id_ent         = '0;
    id_ent.valid   = issue;
    id_ent.wen     = id_rf_wen;
    id_ent.rd      = id_rd_addr;
    id_ent.is_load = id_is_load;
  end

  // Shadow pipeline advances every cycle; ID enters only when issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
    end else begin
      ent_q[0] <= issue ? id_ent : '0;
      for (int k = 1; k < DEPTH; k++) ent_q[k] <= ent_q[k-1];
    end
  end

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
